// File: rtl/csa_accumulator.sv
// Carry-save multi-operand accumulator: one full-adder row per accepted operand, then iterative
// carry resolution to a binary sum on a valid/ready output. Optional operand counter: CSA_ACC_COUNT_EN.
module csa_accumulator #(
    parameter int WIDTH = 8,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             clear,
    input  logic             resolve_req,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
`ifdef CSA_ACC_COUNT_EN
    output logic [ACC_W-1:0] out_count,
`endif
    output logic             out_ovf
);

    typedef enum logic [1:0] {
        ST_ACCUM   = 2'd0,
        ST_RESOLVE = 2'd1,
        ST_OUTPUT  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   sum_q, sum_d;
    logic [ACC_W-1:0]   carry_q, carry_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   out_sum_q, out_sum_d;
    logic               out_ovf_q, out_ovf_d;

    logic [ACC_W-1:0]   x_ext;
    logic [ACC_W-1:0]   s_base, c_base, maj, fold;
    logic               ovf_base;
    logic               accept;

`ifdef CSA_ACC_COUNT_EN
    logic [ACC_W-1:0]   cnt_q, cnt_d, cnt_base;
    logic [ACC_W-1:0]   out_count_q, out_count_d;
`endif

    function automatic logic [ACC_W-1:0] maj3(input logic [ACC_W-1:0] a,
                                              input logic [ACC_W-1:0] b,
                                              input logic [ACC_W-1:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    assign in_ready  = (state_q == ST_ACCUM);
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_ovf   = out_ovf_q;
`ifdef CSA_ACC_COUNT_EN
    assign out_count = out_count_q;
`endif

    assign x_ext  = {{(ACC_W-WIDTH){1'b0}}, in_data};
    assign accept = in_valid && (state_q == ST_ACCUM);

    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_ovf_d   = out_ovf_q;
        // clear takes effect before any operand accepted in the same cycle
        s_base      = clear ? '0 : sum_q;
        c_base      = clear ? '0 : carry_q;
        ovf_base    = clear ? 1'b0 : ovf_q;
        maj         = maj3(s_base, c_base, x_ext);
        fold        = sum_q & carry_q;
`ifdef CSA_ACC_COUNT_EN
        cnt_d       = cnt_q;
        out_count_d = out_count_q;
        cnt_base    = clear ? '0 : cnt_q;
`endif

        unique case (state_q)
            ST_ACCUM: begin
                if (accept) begin
                    sum_d   = s_base ^ c_base ^ x_ext;
                    carry_d = {maj[ACC_W-2:0], 1'b0};
                    ovf_d   = ovf_base | maj[ACC_W-1];
                end else begin
                    sum_d   = s_base;
                    carry_d = c_base;
                    ovf_d   = ovf_base;
                end
`ifdef CSA_ACC_COUNT_EN
                if (accept && (cnt_base != '1))
                    cnt_d = cnt_base + 1'b1;
                else
                    cnt_d = cnt_base;
`endif
                if (resolve_req)
                    state_d = ST_RESOLVE;
            end

            ST_RESOLVE: begin
                if (carry_q == '0) begin
                    out_sum_d   = sum_q;
                    out_ovf_d   = ovf_q;
                    out_valid_d = 1'b1;
`ifdef CSA_ACC_COUNT_EN
                    out_count_d = cnt_q;
`endif
                    state_d     = ST_RESOLVE == state_q ? ST_OUTPUT : state_q;
                end else begin
                    // half-adder step; a carry pushed past the MSB is lost and recorded
                    sum_d   = sum_q ^ carry_q;
                    carry_d = {fold[ACC_W-2:0], 1'b0};
                    ovf_d   = ovf_q | fold[ACC_W-1];
                end
            end

            ST_OUTPUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    sum_d       = '0;
                    carry_d     = '0;
                    ovf_d       = 1'b0;
`ifdef CSA_ACC_COUNT_EN
                    cnt_d       = '0;
`endif
                    state_d     = ST_ACCUM;
                end
            end

            default: state_d = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACCUM;
            sum_q       <= '0;
            carry_q     <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

`ifdef CSA_ACC_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            out_count_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            out_count_q <= out_count_d;
        end
    end
`endif

endmodule

// File: tb/tb_csa_accumulator.sv
// Bench for csa_accumulator (WIDTH=8, ACC_W=16): directed table, corner sequences and
// randomized streams checked against an integer-sum reference model.
module tb_csa_accumulator;

    localparam int WIDTH = 8;
    localparam int ACC_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             clear = 1'b0;
    logic             resolve_req = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [ACC_W-1:0] out_sum;
    logic             out_ovf;
`ifdef CSA_ACC_COUNT_EN
    logic [ACC_W-1:0] out_count;
`endif

    int vectors = 0;
    int miscompares = 0;

    // Reference model: plain integer running total and operand count
    longint m_sum = 0;
    longint m_cnt = 0;

    csa_accumulator #(.WIDTH(WIDTH), .ACC_W(ACC_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .clear       (clear),
        .resolve_req (resolve_req),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sum     (out_sum),
`ifdef CSA_ACC_COUNT_EN
        .out_count   (out_count),
`endif
        .out_ovf     (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] x, input logic clr);
        check("push_in_ready", in_ready, 1'b1);
        in_valid = 1'b1;
        in_data  = x;
        clear    = clr;
        @(posedge clk); #1;
        in_valid = 1'b0;
        clear    = 1'b0;
        if (clr) begin
            m_sum = 0;
            m_cnt = 0;
        end
        m_sum += x;
        if (m_cnt < 65535) m_cnt++;
    endtask

    // Issues resolve_req (in_valid/in_data may already be set by caller for a same-cycle operand),
    // waits for the result, holds off out_ready for rdy_delay cycles while junk input is offered.
    task automatic do_resolve(input string name, input int rdy_delay, input logic noisy,
                              input logic [15:0] exp_sum, input logic exp_ovf,
                              input logic [15:0] exp_cnt);
        int lat;
        resolve_req = 1'b1;
        @(posedge clk); #1;
        resolve_req = 1'b0;
        in_valid    = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            if (noisy) begin
                in_valid = 1'($urandom_range(0, 1));
                clear    = 1'($urandom_range(0, 1));
                in_data  = 8'($urandom_range(0, 255));
            end
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_valid"}, out_valid, 1'b1);
        if (!out_valid) begin
            in_valid = 1'b0;
            clear    = 1'b0;
            return;
        end
        check({name, "_latency_in_range"}, (lat >= 2 && lat <= ACC_W + 1), 1'b1);
        check({name, "_sum"}, out_sum, exp_sum);
        check({name, "_ovf"}, out_ovf, exp_ovf);
`ifdef CSA_ACC_COUNT_EN
        check({name, "_count"}, out_count, exp_cnt);
`else
        if (exp_cnt != exp_cnt) check({name, "_count"}, 0, 1);
`endif
        for (int i = 0; i < rdy_delay; i++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom_range(0, 255));
            clear    = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            check({name, "_hold_sum"}, out_sum, exp_sum);
            check({name, "_hold_valid"}, out_valid, 1'b1);
            check({name, "_hold_in_ready"}, in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        clear     = 1'b0;
        check({name, "_valid_drop"}, out_valid, 1'b0);
        check({name, "_sum_kept"}, out_sum, exp_sum);
        check({name, "_ready_back"}, in_ready, 1'b1);
        m_sum = 0;
        m_cnt = 0;
    endtask

    typedef struct {
        int         n;
        logic [7:0] d [4];
        logic [15:0] s;
        logic       o;
    } vec_t;

    vec_t tbl [5];

    initial begin
        tbl[0] = '{3, '{8'hFF, 8'hFF, 8'hFF, 8'h00}, 16'h02FD, 1'b0};
        tbl[1] = '{0, '{8'h00, 8'h00, 8'h00, 8'h00}, 16'h0000, 1'b0};
        tbl[2] = '{4, '{8'h01, 8'h02, 8'h03, 8'h04}, 16'h000A, 1'b0};
        tbl[3] = '{2, '{8'h80, 8'h80, 8'h00, 8'h00}, 16'h0100, 1'b0};
        tbl[4] = '{4, '{8'hAA, 8'h55, 8'hF0, 8'h0F}, 16'h01FE, 1'b0};

        // Reset state
        #12;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_sum", out_sum, 16'h0);
        check("rst_out_ovf", out_ovf, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table
        for (int t = 0; t < 5; t++) begin
            for (int k = 0; k < tbl[t].n; k++) push(tbl[t].d[k], 1'b0);
            do_resolve($sformatf("tbl%0d", t), t, 1'b0, tbl[t].s, tbl[t].o, 16'(tbl[t].n));
        end

        // Async reset mid-stream while a previous result is still on out_sum
        push(8'hFF, 1'b0); push(8'hFF, 1'b0); push(8'hFF, 1'b0);
        do_resolve("basic", 0, 1'b0, 16'h02FD, 1'b0, 16'd3);
        push(8'h11, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 1'b0);
        check("async_rst_sum", out_sum, 16'h0);
        check("async_rst_ovf", out_ovf, 1'b0);
        check("async_rst_in_ready", in_ready, 1'b1);
        m_sum = 0; m_cnt = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_valid", out_valid, 1'b0);
        check("post_rst_sum", out_sum, 16'h0);
        do_resolve("post_rst_empty", 0, 1'b0, 16'h0000, 1'b0, 16'd0);

        // Overflow: 258 * 0xFF = 0x100FE
        for (int i = 0; i < 258; i++) push(8'hFF, 1'b0);
        do_resolve("overflow", 1, 1'b0, 16'h00FE, 1'b1, 16'd258);

        // Clear and handshake in the same cycle
        push(8'd5, 1'b0);
        push(8'd7, 1'b1);
        do_resolve("clear_order", 0, 1'b0, 16'd7, 1'b0, 16'd1);

        // Backpressure with offered operands, then a fresh accumulation
        push(8'h10, 1'b0); push(8'h20, 1'b0);
        do_resolve("backpressure", 5, 1'b0, 16'h0030, 1'b0, 16'd2);
        push(8'h01, 1'b0);
        do_resolve("after_bp", 0, 1'b0, 16'h0001, 1'b0, 16'd1);

        // Operand accepted in the same cycle as resolve_req is included
        push(8'h40, 1'b0);
        in_valid = 1'b1; in_data = 8'h02;
        do_resolve("req_with_op", 0, 1'b1, 16'h0042, 1'b0, 16'd2);

        // Reset mid-RESOLVE: no output pulse, accumulator emptied
        push(8'hAA, 1'b0); push(8'h55, 1'b0);
        resolve_req = 1'b1;
        @(posedge clk); #1;
        resolve_req = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_resolve_rst_valid", out_valid, 1'b0);
        check("mid_resolve_rst_in_ready", in_ready, 1'b1);
        m_sum = 0; m_cnt = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("mid_resolve_no_pulse", out_valid, 1'b0);
        end
        do_resolve("mid_resolve_fresh", 0, 1'b0, 16'h0000, 1'b0, 16'd0);

        // Randomized streams against the integer model
        for (int r = 0; r < 30; r++) begin
            int n;
            logic [7:0] x;
            n = $urandom_range(0, 14);
            for (int k = 0; k < n; k++) begin
                x = 8'($urandom_range(0, 255));
                push(x, ($urandom_range(0, 7) == 0));
                if ($urandom_range(0, 3) == 0) begin
                    clear = ($urandom_range(0, 4) == 0);
                    @(posedge clk); #1;
                    if (clear) begin m_sum = 0; m_cnt = 0; end
                    clear = 1'b0;
                end
            end
            if ($urandom_range(0, 2) == 0) begin
                x = 8'($urandom_range(0, 255));
                in_valid = 1'b1; in_data = x;
                m_sum += x;
                m_cnt++;
            end
            do_resolve($sformatf("rand%0d", r), $urandom_range(0, 3), 1'b1,
                       16'(m_sum), (m_sum >= 65536), 16'(m_cnt));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/csa_accumulator.md
Name: csa_accumulator

Overview:
- Parametrised, sequential successor to the team's single-bit full-adder cell.
- Accumulates a stream of WIDTH-bit unsigned operands into an ACC_W-bit carry-save pair (sum/carry vectors), using one full-adder row per operand.
- On request, iteratively resolves the pair to a binary result and presents it on a valid/ready output.
- Feeds the Wallace-tree datapath and any multi-operand summation stage.

Parameters:
- WIDTH, 8: operand width in bits.
- ACC_W, 16: accumulator width in bits. Must satisfy ACC_W >= WIDTH+1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand presented.
- in_ready  output  1  block can accept an operand.
- in_data  input  WIDTH  operand, zero-extended to ACC_W.
- clear  input  1  synchronous clear of the accumulator.
- resolve_req  input  1  request final sum.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_sum  output  ACC_W  resolved sum, modulo 2^ACC_W.
- out_ovf  output  1  sticky: a carry was lost past the MSB.

Behaviour:
- Reset (async, rst_n=0):
  - State ACCUM; sum_r=0, carry_r=0, ovf_r=0.
  - out_valid=0, out_sum=0, out_ovf=0, in_ready=1.
- States: ACCUM, RESOLVE, OUTPUT.
- ACCUM:
  - in_ready=1.
  - Handshake: in_valid & in_ready.
  - On handshake, per bit i, with x = zero-extended in_data:
    - sum_r[i] <= s^c^x.
    - maj[i] = majority(s,c,x).
    - carry_r <= {maj[ACC_W-2:0],0}.
    - If maj[ACC_W-1]=1, set ovf_r.
  - clear=1: sum_r, carry_r and ovf_r go to 0 this cycle. If a handshake occurs in the same cycle, clear is applied first, then the operand is added, so sum_r=x.
  - resolve_req=1: go to RESOLVE next cycle. Any operand accepted in that same cycle is included.
- RESOLVE:
  - in_ready=0; clear and in_valid are ignored.
  - Each cycle:
    - If carry_r==0: out_sum<=sum_r, out_ovf<=ovf_r, out_valid<=1, go to OUTPUT.
    - Else: sum_r <= sum_r^carry_r; carry_r <= (sum_r&carry_r)<<1. A bit shifted out of the MSB sets ovf_r.
  - Latency from the resolve_req cycle to out_valid: 2 cycles minimum (carry_r already 0), ACC_W+1 cycles maximum.
- OUTPUT:
  - in_ready=0; out_sum and out_ovf hold stable while out_ready=0.
  - On out_valid & out_ready:
    - out_valid<=0.
    - sum_r, carry_r and ovf_r are cleared.
    - Go to ACCUM next cycle. out_sum holds its last value.
- resolve_req outside ACCUM is ignored. resolve_req with an empty accumulator yields out_sum=0.
- Reset mid-RESOLVE or mid-OUTPUT aborts immediately to the reset values. There is no partial output.
- Arithmetic is unsigned, modulo 2^ACC_W. out_ovf=1 iff the true sum is >= 2^ACC_W.

Optional Feature:
- Macro: CSA_ACC_COUNT_EN.
- Defined:
  - Adds output port out_count, width ACC_W, reset 0.
  - Counts operands accepted since the last clear or output handshake, saturating at all-ones.
  - Captured into out_count alongside out_sum on entry to OUTPUT; held during OUTPUT.
  - The internal count obeys the same clear/handshake ordering as sum_r: clear plus handshake gives count=1.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: assert rst_n=0 mid-stream -> out_valid=0, out_sum=0, out_ovf=0, in_ready=1 immediately (async); stays so after release.
- Basic sum (WIDTH=8, ACC_W=16): accept 8'hFF three times, then resolve_req -> out_sum=16'h02FD, out_ovf=0, out_valid within 17 cycles of the request.
- Overflow: accept 8'hFF 258 times, then resolve -> out_sum=16'h00FE, out_ovf=1 (true sum 0x100FE).
- Clear ordering: accept 8'd5; then one cycle with clear=1, in_valid=1, in_data=8'd7; then resolve -> out_sum=16'd7, out_ovf=0 (with CSA_ACC_COUNT_EN: out_count=1).
- Backpressure: result 16'h0030 with out_ready=0 for 5 cycles, in_valid=1 meanwhile -> out_sum stable, in_ready=0, no operand absorbed. After out_ready=1, the next accepted 8'h01 plus resolve gives 16'h0001.
- Reset mid-RESOLVE: accumulate 8'hAA and 8'h55, pulse resolve_req, drop rst_n one cycle later -> no out_valid pulse; after release a fresh resolve gives out_sum=0.
